regfile_wb_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single write port of the 64x32 register file

---
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Picks one writeback source per cycle, registers its address/data onto
// rd/wd/RegWrite one cycle later, drops writes to r0 and counts cycles
// with two or more pending requesters.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*6-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  stall,
  output logic [5:0]            rd,
  output logic [31:0]           wd,
  output logic                  RegWrite,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [PTR_W:0]   idx;
  logic [3:0]       nvalid;
  logic             multi_req;
  logic [5:0]       gnt_addr;
  logic [31:0]      gnt_data;

  logic [5:0]       rd_q, rd_d;
  logic [31:0]      wd_q, wd_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Scan from rr_ptr with wrap; first valid requester wins unless stalled or in reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx >= NUM_REQ_X) idx = idx - NUM_REQ_X;
      if (!gnt_any && req_valid[idx[PTR_W-1:0]] && !stall && RST_N) begin
        gnt_any = 1'b1;
        gnt_idx = idx[PTR_W-1:0];
      end
    end
  end

  // One-hot grant back to the requesters.
  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Contention detect: two or more requesters pending this cycle.
  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) nvalid = nvalid + 4'(req_valid[i]);
    multi_req = (nvalid >= 4'd2);
  end

  // Next-state: pointer advance, write stage load, saturating counter.
  always_comb begin
    gnt_addr = req_addr[int'(gnt_idx)*6 +: 6];
    gnt_data = req_data[int'(gnt_idx)*32 +: 32];
    rr_ptr_d = rr_ptr_q;
    rd_d     = rd_q;
    wd_d     = wd_q;
    we_d     = 1'b0;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_MAX) ? '0 : gnt_idx + PTR_W'(1);
      rd_d     = gnt_addr;
      wd_d     = gnt_data;
      // r0 is hardwired to zero: accept the request but never enable the write.
      we_d     = (gnt_addr != 6'd0);
    end
    cnt_d = cnt_q;
    if (multi_req && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; async reset also discards any pending registered write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_q <= '0;
      rd_q     <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd           = rd_q;
  assign wd           = wd_q;
  assign RegWrite     = we_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus constrained-random
// traffic, all checked against a behavioural round-robin model.
module tb_regfile_wb_arbiter;
  localparam int N = 3;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    req_valid;
  logic [N*6-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic            stall;
  logic [N-1:0]    req_ready, ready4;
  logic [5:0]      rd, rd4;
  logic [31:0]     wd, wd4;
  logic            RegWrite, we4;
  logic [15:0]     conflict_cnt;
  logic [3:0]      cnt4;

  regfile_wb_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall), .rd(rd), .wd(wd),
    .RegWrite(RegWrite), .conflict_cnt(conflict_cnt));

  regfile_wb_arbiter #(.NUM_REQ(N), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(ready4), .stall(stall), .rd(rd4), .wd(wd4),
    .RegWrite(we4), .conflict_cnt(cnt4));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int          m_ptr;
  logic [5:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_we;
  int          m_cnt, m_cnt4;

  function automatic int winner();
    if (stall) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    logic [N-1:0] r;
    w = winner();
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rd = '0; m_wd = '0; m_we = 1'b0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_update();
    int w;
    w = winner();
    if (w >= 0) begin
      m_rd  = req_addr[w*6 +: 6];
      m_wd  = req_data[w*32 +: 32];
      m_we  = (m_rd != 6'd0);
      m_ptr = (w + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    if ($countones(req_valid) >= 2) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  // Advance one clock; returns 1ns after the edge.
  task automatic tick();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [31:0] d);
    req_addr[i*6 +: 6]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    stall = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    set_req(0, 6'd1, 32'h11); set_req(1, 6'd2, 32'h22); set_req(2, 6'd3, 32'h33);
    stall = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    checks++; if (rd !== 6'd0 || wd !== 32'd0) begin errors++; $display("FAIL reset_rd_wd: got %0d/%h want 0/0", rd, wd); end
    checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
    req_valid = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    // reset asserted while a write is sitting in the write stage
    req_valid = 3'b001;
    set_req(0, 6'd9, 32'hA5A5_0001);
    #2;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL midreset_grant: got %b want 001", req_ready); end
    tick();
    checks++; if (RegWrite !== 1'b1 || rd !== 6'd9) begin errors++; $display("FAIL midreset_pre: got we=%b rd=%0d want we=1 rd=9", RegWrite, rd); end
    req_valid = '0;
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0 || rd !== 6'd0) begin errors++; $display("FAIL midreset_async: got we=%b rd=%0d want we=0 rd=0", RegWrite, rd); end
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid = 3'b010;
    set_req(1, 6'd5, 32'hDEADBEEF);
    #2;
    checks++; if (req_ready !== 3'b010 || req_ready !== exp_ready()) begin errors++; $display("FAIL single_ready: got %b want 010", req_ready); end
    tick();
    checks++; if (RegWrite !== 1'b1 || rd !== 6'd5 || wd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write: got we=%b rd=%0d wd=%h want 1/5/deadbeef", RegWrite, rd, wd); end
    req_valid = 3'b111;
    #2;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL single_ptr: got %b want 100", req_ready); end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int cnt0;
    cnt0 = m_cnt;
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) set_req(i, 6'(10 + i), 32'hC0DE_0000 + i);
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] want;
      want = '0;
      want[k % N] = 1'b1;
      #2;
      checks++; if (req_ready !== want) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, want); end
      tick();
      checks++; if (RegWrite !== 1'b1 || rd !== 6'(10 + k % N)) begin errors++; $display("FAIL rr_write%0d: got we=%b rd=%0d want 1/%0d", k, RegWrite, rd, 10 + k % N); end
    end
    checks++; if (conflict_cnt !== 16'(cnt0 + 6)) begin errors++; $display("FAIL rr_cnt: got %0d want %0d", conflict_cnt, cnt0 + 6); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_r0_drop();
    req_valid = 3'b001;
    set_req(0, 6'd0, 32'h1234);
    #2;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL r0_ready: got %b want 001", req_ready); end
    tick();
    checks++; if (RegWrite !== 1'b0 || wd !== 32'h1234) begin errors++; $display("FAIL r0_write: got we=%b wd=%h want 0/1234", RegWrite, wd); end
    req_valid = 3'b111;
    #2;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL r0_ptr: got %b want 010", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    req_valid = 3'b010;
    set_req(1, 6'd20, 32'h2020);
    set_req(2, 6'd21, 32'h2121);
    #2;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL stall_pre: got %b want 010", req_ready); end
    tick();
    req_valid = 3'b100;
    stall = 1'b1;
    #2;
    checks++; if (RegWrite !== 1'b1 || rd !== 6'd20) begin errors++; $display("FAIL stall_drain: got we=%b rd=%0d want 1/20", RegWrite, rd); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready%0d: got %b want 000", k, req_ready); end
      tick();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL stall_we%0d: got %b want 0", k, RegWrite); end
      #2;
    end
    stall = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL stall_release: got %b want 100", req_ready); end
    tick();
    checks++; if (RegWrite !== 1'b1 || rd !== 6'd21 || wd !== 32'h2121) begin errors++; $display("FAIL stall_write: got we=%b rd=%0d wd=%h want 1/21/2121", RegWrite, rd, wd); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    g = '0;
    req_valid = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        // an ungranted requester must keep its request stable
        if (!(req_valid[i] && !g[i])) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63)), $urandom);
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      #2;
      g = exp_ready();
      checks++; if (req_ready !== g) begin errors++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, g); end
      tick();
      checks++; if (RegWrite !== m_we || rd !== m_rd || wd !== m_wd) begin errors++; $display("FAIL rand_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c, RegWrite, rd, wd, m_we, m_rd, m_wd); end
      checks++; if (conflict_cnt !== 16'(m_cnt) || cnt4 !== 4'(m_cnt4)) begin errors++; $display("FAIL rand_cnt c=%0d: got %0d/%0d want %0d/%0d", c, conflict_cnt, cnt4, m_cnt, m_cnt4); end
    end
    req_valid = '0;
    stall = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    req_valid = 3'b111;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 14) begin
        checks++; if (cnt4 !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d want 14", cnt4); end
      end
      if (k >= 15) begin
        checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_hold%0d: got %0d want 15", k, cnt4); end
      end
    end
    checks++; if (conflict_cnt !== 16'd23 || conflict_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL sat_wide: got %0d want 23", conflict_cnt); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    RST_N = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    stall = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_r0_drop();
    test_stall();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
